// File: rtl/button_event_decoder.sv
// button_event_decoder
// Turns the clean, synchronous button level from the debounce stage into
// single-cycle event pulses: short press, long press and double click.
// Optional feature macro: REPEAT_EN adds an auto-repeat tick while the button
// stays held after a long press; without it repeat_tick is tied low.

module button_event_decoder #(
    parameter int LONG_CYC = 20_000_000,
    parameter int DBL_CYC  = 5_000_000,
    parameter int REP_CYC  = 2_500_000,
    parameter int CNT_W    = 25
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_level,
    output logic short_press,
    output logic long_press,
    output logic double_click,
    output logic repeat_tick,
    output logic held
);

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        WAIT2,
        WAITR,
        LONGH
    } state_e;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_CYC - 1);

    // The timer has to reach every terminal count, so refuse to build otherwise.
    if ((LONG_CYC < 1) || (DBL_CYC < 1) || (REP_CYC < 1) ||
        ($clog2(LONG_CYC) > CNT_W) || ($clog2(DBL_CYC) > CNT_W) ||
        ($clog2(REP_CYC) > CNT_W)) begin : g_bad_params
        $error("button_event_decoder: CNT_W too narrow or zero cycle count");
    end

`ifdef REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REP_CYC - 1);
`endif

    state_e           state_q;
    logic [CNT_W-1:0] timer_q;
    logic             btn_q;
    logic             short_q;
    logic             long_q;
    logic             dbl_q;
    logic             rep_q;
    logic             rise;
    logic             fall;

    assign rise = btn_level & ~btn_q;
    assign fall = ~btn_level & btn_q;

    assign short_press  = short_q;
    assign long_press   = long_q;
    assign double_click = dbl_q;
    assign repeat_tick  = rep_q;
    assign held         = btn_q;

    // Event FSM: tracks the press/release sequence, runs the shared timer and
    // registers the one-cycle event pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            btn_q   <= 1'b0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            dbl_q   <= 1'b0;
            rep_q   <= 1'b0;
        end else begin
            btn_q   <= btn_level;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            dbl_q   <= 1'b0;
            rep_q   <= 1'b0;
            if (!(&timer_q)) begin
                timer_q <= timer_q + 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_q <= PRESS1;
                        timer_q <= '0;
                    end
                end
                PRESS1: begin
                    // A release landing on the long-press count loses to the long press.
                    if (timer_q == LONG_LAST) begin
                        long_q  <= 1'b1;
                        state_q <= LONGH;
                        timer_q <= '0;
                    end else if (fall) begin
                        state_q <= WAIT2;
                        timer_q <= '0;
                    end
                end
                WAIT2: begin
                    // A second press on the very last gap cycle still counts as a double.
                    if (rise) begin
                        dbl_q   <= 1'b1;
                        state_q <= WAITR;
                        timer_q <= '0;
                    end else if (timer_q == DBL_LAST) begin
                        short_q <= 1'b1;
                        state_q <= IDLE;
                        timer_q <= '0;
                    end
                end
                WAITR: begin
                    if (!btn_level) begin
                        state_q <= IDLE;
                        timer_q <= '0;
                    end
                end
                LONGH: begin
                    if (!btn_level) begin
                        state_q <= IDLE;
                        timer_q <= '0;
                    end
`ifdef REPEAT_EN
                    else if (timer_q == REP_LAST) begin
                        rep_q   <= 1'b1;
                        timer_q <= '0;
                    end
`endif
                end
                default: begin
                    state_q <= IDLE;
                    timer_q <= '0;
                end
            endcase
        end
    end

endmodule
